enemy_hit_judge_multi: RTL and testbench

- Multi-slot successor of the single-enemy collision/health judge.
- Tracks up to N_ENEMY enemies, each with its own health counter and explosion timer.
- Tests one player bullet per cycle against all enemy hitboxes, charges at most one hit per bullet, and reports the hit, per-slot health, explosion (boom) and dead status to the renderer and score logic.
- Sits between the bullet/enemy movement blocks and the VGA sprite mux.

---
 rtl/enemy_hit_judge_multi.sv | 147 ++++++++++++++
 tb/tb_enemy_hit_judge_multi.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_hit_judge_multi.sv
// Multi-slot enemy collision and health judge: one bullet per cycle is tested against every
// enemy hitbox, the lowest overlapping slot is charged, and per-slot explosions are timed on tick.
module enemy_hit_judge_multi #(
  parameter int unsigned N_ENEMY    = 4,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned HP_W       = 3,
  parameter int unsigned ENE_W      = 60,
  parameter int unsigned ENE_H      = 90,
  parameter int unsigned BUL_W      = 10,
  parameter int unsigned BUL_H      = 40,
  parameter int unsigned Y_OFS      = 0,
  parameter int unsigned BOOM_TICKS = 8,
  localparam int unsigned IdxW      = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick_i,
  input  logic [N_ENEMY-1:0]         load_i,
  input  logic [HP_W-1:0]            hp_init_i,
  input  logic [N_ENEMY*COORD_W-1:0] enemy_x_i,
  input  logic [N_ENEMY*COORD_W-1:0] enemy_y_i,
  input  logic [N_ENEMY-1:0]         enemy_en_i,
  input  logic                       bullet_valid_i,
  input  logic [COORD_W-1:0]         b_x_i,
  input  logic [COORD_W-1:0]         b_y_i,
  output logic                       bullet_hit_o,
  output logic [IdxW-1:0]            hit_idx_o,
  output logic [N_ENEMY*HP_W-1:0]    health_o,
  output logic [N_ENEMY-1:0]         boom_o,
  output logic [N_ENEMY-1:0]         dead_o,
  output logic                       kill_pulse_o
);

  // Two guard bits keep every sum exact, so hitboxes near the screen edge never wrap.
  localparam int unsigned CW = COORD_W + 2;
  localparam int unsigned TW = $clog2(BOOM_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StAlive, StExplode, StDead} slot_st_e;

  slot_st_e           state_q  [N_ENEMY];
  logic [HP_W-1:0]    health_q [N_ENEMY];
  logic [TW-1:0]      timer_q  [N_ENEMY];
  logic [N_ENEMY-1:0] boom_q, dead_q;
  logic               bullet_hit_q, kill_pulse_q, consumed_q;
  logic [IdxW-1:0]    hit_idx_q;

  logic [N_ENEMY-1:0] eligible;
  logic               hit;
  logic               kill;
  logic [IdxW-1:0]    win_idx;
  logic [CW-1:0]      bx, by;

  assign bx = {2'b00, b_x_i};
  assign by = {2'b00, b_y_i};

  for (genvar g = 0; g < N_ENEMY; g++) begin : g_slot
    logic [CW-1:0] ex, ey;
    logic          overlap;

    assign ex      = {2'b00, enemy_x_i[g*COORD_W +: COORD_W]};
    assign ey      = {2'b00, enemy_y_i[g*COORD_W +: COORD_W]} + CW'(Y_OFS);
    assign overlap = (bx < ex + CW'(ENE_W)) && (ex < bx + CW'(BUL_W)) &&
                     (by < ey + CW'(ENE_H)) && (ey < by + CW'(BUL_H));

    assign eligible[g] = (state_q[g] == StAlive) && enemy_en_i[g] && !load_i[g] &&
                         bullet_valid_i && !consumed_q && overlap;

    assign health_o[g*HP_W +: HP_W] = health_q[g];
  end

  // Lowest eligible index wins; scanning downward leaves it as the final assignment.
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        hit     = 1'b1;
        win_idx = IdxW'(i);
      end
    end
    kill = hit && (health_q[win_idx] == HP_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bullet_hit_q <= 1'b0;
      kill_pulse_q <= 1'b0;
      consumed_q   <= 1'b0;
      hit_idx_q    <= '0;
      boom_q       <= '0;
      dead_q       <= '0;
      for (int i = 0; i < N_ENEMY; i++) begin
        state_q[i]  <= StIdle;
        health_q[i] <= '0;
        timer_q[i]  <= '0;
      end
    end else begin
      bullet_hit_q <= hit;
      kill_pulse_q <= kill;
      // Held until the bullet leaves flight so a lingering bullet cannot score twice.
      consumed_q   <= hit || (consumed_q && bullet_valid_i);
      if (hit) begin
        hit_idx_q <= win_idx;
      end
      for (int i = 0; i < N_ENEMY; i++) begin
        if (load_i[i] && (hp_init_i != '0)) begin
          state_q[i]  <= StAlive;
          health_q[i] <= hp_init_i;
          timer_q[i]  <= '0;
          boom_q[i]   <= 1'b0;
          dead_q[i]   <= 1'b0;
        end else begin
          unique case (state_q[i])
            StAlive: begin
              if (hit && (win_idx == IdxW'(i))) begin
                health_q[i] <= health_q[i] - HP_W'(1);
                if (health_q[i] == HP_W'(1)) begin
                  state_q[i] <= StExplode;
                  timer_q[i] <= TW'(BOOM_TICKS);
                  boom_q[i]  <= 1'b1;
                end
              end
            end
            StExplode: begin
              if (tick_i) begin
                timer_q[i] <= timer_q[i] - TW'(1);
                if (timer_q[i] == TW'(1)) begin
                  state_q[i] <= StDead;
                  boom_q[i]  <= 1'b0;
                  dead_q[i]  <= 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bullet_hit_o = bullet_hit_q;
  assign kill_pulse_o = kill_pulse_q;
  assign hit_idx_o    = hit_idx_q;
  assign boom_o       = boom_q;
  assign dead_o       = dead_q;

endmodule

// File: tb/tb_enemy_hit_judge_multi.sv
// Bench for enemy_hit_judge_multi: directed scenarios plus randomized traffic, all checked
// against a slot-level behavioural model stepped once per clock.
module tb_enemy_hit_judge_multi;
  localparam int N  = 4;
  localparam int CW = 10;
  localparam int HW = 3;
  localparam int EW = 60;
  localparam int EH = 90;
  localparam int BW = 10;
  localparam int BH = 40;
  localparam int YO = 0;
  localparam int BT = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tick = 1'b0;
  logic [N-1:0]    load = '0;
  logic [HW-1:0]   hp_init = '0;
  logic [N*CW-1:0] enemy_x = '0;
  logic [N*CW-1:0] enemy_y = '0;
  logic [N-1:0]    en = '0;
  logic            bullet_valid = 1'b0;
  logic [CW-1:0]   b_x = '0;
  logic [CW-1:0]   b_y = '0;

  logic            bullet_hit_o, kill_pulse_o;
  logic [1:0]      hit_idx_o;
  logic [N*HW-1:0] health_o;
  logic [N-1:0]    boom_o, dead_o;

  enemy_hit_judge_multi dut (
    .clk           (clk),
    .rst           (rst),
    .tick_i        (tick),
    .load_i        (load),
    .hp_init_i     (hp_init),
    .enemy_x_i     (enemy_x),
    .enemy_y_i     (enemy_y),
    .enemy_en_i    (en),
    .bullet_valid_i(bullet_valid),
    .b_x_i         (b_x),
    .b_y_i         (b_y),
    .bullet_hit_o  (bullet_hit_o),
    .hit_idx_o     (hit_idx_o),
    .health_o      (health_o),
    .boom_o        (boom_o),
    .dead_o        (dead_o),
    .kill_pulse_o  (kill_pulse_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 empty, 1 alive, 2 exploding, 3 dead; boom_left counts remaining ticks.
  int m_phase [N];
  int m_hp    [N];
  int m_left  [N];
  bit m_cons;

  logic            exp_hit, exp_kill;
  logic [1:0]      exp_idx;
  logic [N*HW-1:0] exp_health;
  logic [N-1:0]    exp_boom, exp_dead;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0;
      m_hp[i]    = 0;
      m_left[i]  = 0;
    end
    m_cons     = 1'b0;
    exp_hit    = 1'b0;
    exp_kill   = 1'b0;
    exp_idx    = '0;
    exp_health = '0;
    exp_boom   = '0;
    exp_dead   = '0;
  endtask

  task automatic set_pos(input int i, input int x, input int y);
    enemy_x[i*CW +: CW] = CW'(x);
    enemy_y[i*CW +: CW] = CW'(y);
  endtask

  function automatic bit overlaps(input int i);
    int ex = int'(enemy_x[i*CW +: CW]);
    int ey = int'(enemy_y[i*CW +: CW]) + YO;
    int bx = int'(b_x);
    int by = int'(b_y);
    return (bx < ex + EW) && (ex < bx + BW) && (by < ey + EH) && (ey < by + BH);
  endfunction

  // Advance the model with the inputs now applied, clock the DUT, then clear the strobes.
  task automatic step();
    int win = -1;
    for (int i = 0; i < N; i++)
      if (win < 0 && m_phase[i] == 1 && en[i] && !load[i] && bullet_valid && !m_cons &&
          overlaps(i))
        win = i;
    exp_hit  = (win >= 0);
    exp_kill = 1'b0;
    if (win >= 0) begin
      exp_idx  = 2'(win);
      exp_kill = (m_hp[win] == 1);
    end
    m_cons = exp_hit || (m_cons && bullet_valid);
    for (int i = 0; i < N; i++) begin
      if (load[i] && hp_init != 0) begin
        m_phase[i] = 1;
        m_hp[i]    = int'(hp_init);
        m_left[i]  = 0;
      end else if (i == win) begin
        m_hp[i] = m_hp[i] - 1;
        if (m_hp[i] == 0) begin
          m_phase[i] = 2;
          m_left[i]  = BT;
        end
      end else if (m_phase[i] == 2 && tick) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) m_phase[i] = 3;
      end
      exp_health[i*HW +: HW] = HW'(m_hp[i]);
      exp_boom[i] = (m_phase[i] == 2);
      exp_dead[i] = (m_phase[i] == 3);
    end
    @(posedge clk);
    #1;
    load = '0;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bullet_hit_o, kill_pulse_o, hit_idx_o, boom_o, dead_o, health_o} !== '0) begin
      bad++;
      $display("FAIL reset: hit=%b kill=%b idx=%0d boom=%b dead=%b hp=%h, want all zero",
               bullet_hit_o, kill_pulse_o, hit_idx_o, boom_o, dead_o, health_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_hit();
    int hits = 0;
    set_pos(0, 100, 100);
    en[0] = 1'b1;
    hp_init = 3'd3;
    load[0] = 1'b1;
    step();
    b_x = 10'd120;
    b_y = 10'd150;
    bullet_valid = 1'b1;
    repeat (5) begin
      step();
      hits += int'(bullet_hit_o);
      total++;
      if ({bullet_hit_o, kill_pulse_o, boom_o, dead_o, health_o} !==
          {exp_hit, exp_kill, exp_boom, exp_dead, exp_health}) begin
        bad++;
        $display("FAIL single_hit: hit=%b kill=%b boom=%b dead=%b hp=%h, want %b %b %b %b %h",
                 bullet_hit_o, kill_pulse_o, boom_o, dead_o, health_o,
                 exp_hit, exp_kill, exp_boom, exp_dead, exp_health);
      end
      if (exp_hit) begin
        total++;
        if (hit_idx_o !== exp_idx) begin
          bad++;
          $display("FAIL single_hit idx: got %0d want %0d", hit_idx_o, exp_idx);
        end
      end
    end
    total++;
    if (hits != 1 || health_o[2:0] !== 3'd2) begin
      bad++;
      $display("FAIL single_hit count: hits=%0d hp0=%0d, want hits=1 hp0=2", hits, health_o[2:0]);
    end
    bullet_valid = 1'b0;
    step();
  endtask

  task automatic test_priority();
    set_pos(1, 300, 100);
    set_pos(2, 310, 120);
    en[2:1] = 2'b11;
    hp_init = 3'd3;
    load = 4'b0110;
    step();
    b_x = 10'd320;
    b_y = 10'd150;
    bullet_valid = 1'b1;
    repeat (3) begin
      step();
      total++;
      if ({bullet_hit_o, kill_pulse_o, boom_o, dead_o, health_o} !==
          {exp_hit, exp_kill, exp_boom, exp_dead, exp_health}) begin
        bad++;
        $display("FAIL priority: hit=%b kill=%b boom=%b dead=%b hp=%h, want %b %b %b %b %h",
                 bullet_hit_o, kill_pulse_o, boom_o, dead_o, health_o,
                 exp_hit, exp_kill, exp_boom, exp_dead, exp_health);
      end
      if (exp_hit) begin
        total++;
        if (hit_idx_o !== 2'd1) begin
          bad++;
          $display("FAIL priority idx: got %0d want 1", hit_idx_o);
        end
      end
    end
    total++;
    if (health_o[5:3] !== 3'd2 || health_o[8:6] !== 3'd3) begin
      bad++;
      $display("FAIL priority hp: hp1=%0d hp2=%0d, want 2 and 3", health_o[5:3], health_o[8:6]);
    end
    bullet_valid = 1'b0;
    step();
  endtask

  task automatic test_kill();
    int kills = 0;
    int hits  = 0;
    set_pos(3, 600, 100);
    en[3] = 1'b1;
    hp_init = 3'd1;
    load[3] = 1'b1;
    step();
    b_x = 10'd610;
    b_y = 10'd120;
    bullet_valid = 1'b1;
    repeat (3) begin
      step();
      kills += int'(kill_pulse_o);
    end
    total++;
    if (kills != 1 || boom_o[3] !== 1'b1 || kill_pulse_o !== exp_kill) begin
      bad++;
      $display("FAIL kill: pulses=%0d boom3=%b, want pulses=1 boom3=1", kills, boom_o[3]);
    end
    bullet_valid = 1'b0;
    for (int k = 1; k <= BT; k++) begin
      tick = 1'b1;
      step();
      total++;
      if ({boom_o, dead_o, health_o} !== {exp_boom, exp_dead, exp_health} ||
          boom_o[3] !== (k < BT) || dead_o[3] !== (k == BT)) begin
        bad++;
        $display("FAIL boom tick %0d: boom=%b dead=%b, want boom=%b dead=%b",
                 k, boom_o, dead_o, exp_boom, exp_dead);
      end
      step();
    end
    bullet_valid = 1'b1;
    repeat (3) begin
      step();
      hits += int'(bullet_hit_o);
    end
    total++;
    if (hits != 0 || dead_o[3] !== 1'b1) begin
      bad++;
      $display("FAIL dead slot: hits=%0d dead3=%b, want hits=0 dead3=1", hits, dead_o[3]);
    end
    bullet_valid = 1'b0;
    step();
  endtask

  task automatic test_edges();
    // {b_x, b_y, enemy0_y, hit expected}
    int cases [6][4] = '{'{160, 150, 100, 0}, '{159, 150, 100, 1}, '{90, 150, 100, 0},
                         '{91, 150, 100, 1}, '{120, 1020, 1000, 1}, '{120, 950, 1000, 0}};
    hp_init = 3'd7;
    set_pos(0, 100, 100);
    load[0] = 1'b1;
    step();
    for (int c = 0; c < 6; c++) begin
      set_pos(0, 100, cases[c][2]);
      b_x = CW'(cases[c][0]);
      b_y = CW'(cases[c][1]);
      bullet_valid = 1'b1;
      step();
      total++;
      if (bullet_hit_o !== cases[c][3][0] || health_o !== exp_health ||
          bullet_hit_o !== exp_hit) begin
        bad++;
        $display("FAIL edge case %0d: hit=%b hp=%h, want hit=%0d hp=%h",
                 c, bullet_hit_o, health_o, cases[c][3], exp_health);
      end
      bullet_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_load_during_explode();
    set_pos(0, 100, 100);
    hp_init = 3'd1;
    load[0] = 1'b1;
    step();
    b_x = 10'd120;
    b_y = 10'd150;
    bullet_valid = 1'b1;
    step();
    bullet_valid = 1'b0;
    step();
    tick = 1'b1;
    step();
    hp_init = 3'd5;
    load[0] = 1'b1;
    bullet_valid = 1'b1;
    step();
    total++;
    if (bullet_hit_o !== 1'b0 || boom_o[0] !== 1'b0 || health_o[2:0] !== 3'd5 ||
        boom_o !== exp_boom) begin
      bad++;
      $display("FAIL reload: hit=%b boom=%b hp0=%0d, want hit=0 boom0=0 hp0=5",
               bullet_hit_o, boom_o, health_o[2:0]);
    end
    step();
    total++;
    if ({bullet_hit_o, health_o, boom_o} !== {exp_hit, exp_health, exp_boom}) begin
      bad++;
      $display("FAIL reload follow: hit=%b hp=%h boom=%b, want %b %h %b",
               bullet_hit_o, health_o, boom_o, exp_hit, exp_health, exp_boom);
    end
    bullet_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int hits = 0;
    hp_init = 3'd1;
    load[1] = 1'b1;
    step();
    b_x = 10'd320;
    b_y = 10'd150;
    bullet_valid = 1'b1;
    step();
    total++;
    if ({bullet_hit_o, hit_idx_o, kill_pulse_o, boom_o} !== {exp_hit, exp_idx, exp_kill, exp_boom}) begin
      bad++;
      $display("FAIL pre-reset kill: hit=%b idx=%0d kill=%b boom=%b, want %b %0d %b %b",
               bullet_hit_o, hit_idx_o, kill_pulse_o, boom_o, exp_hit, exp_idx, exp_kill, exp_boom);
    end
    bullet_valid = 1'b0;
    tick = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bullet_hit_o, kill_pulse_o, hit_idx_o, boom_o, dead_o, health_o} !== '0) begin
      bad++;
      $display("FAIL async reset: hit=%b kill=%b idx=%0d boom=%b dead=%b hp=%h, want all zero",
               bullet_hit_o, kill_pulse_o, hit_idx_o, boom_o, dead_o, health_o);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    en = '1;
    bullet_valid = 1'b1;
    repeat (4) begin
      step();
      hits += int'(bullet_hit_o);
    end
    total++;
    if (hits != 0 || health_o !== '0) begin
      bad++;
      $display("FAIL post-reset: hits=%0d hp=%h, want hits=0 hp=0", hits, health_o);
    end
    bullet_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(15) == 0) begin
          load[i] = 1'b1;
          set_pos(i, $urandom_range(200),
                  ($urandom_range(3) == 0) ? $urandom_range(1023, 930) : $urandom_range(200));
        end
        en[i] = ($urandom_range(7) != 0);
      end
      hp_init = HW'($urandom_range(7));
      tick = ($urandom_range(3) == 0);
      if ($urandom_range(3) == 0) begin
        bullet_valid = ~bullet_valid;
        b_x = CW'($urandom_range(250));
        b_y = CW'(($urandom_range(3) == 0) ? $urandom_range(1023, 900) : $urandom_range(250));
      end
      step();
      total++;
      if ({bullet_hit_o, kill_pulse_o, boom_o, dead_o, health_o} !==
          {exp_hit, exp_kill, exp_boom, exp_dead, exp_health} ||
          (exp_hit && hit_idx_o !== exp_idx)) begin
        bad++;
        $display("FAIL random cyc %0d: hit=%b idx=%0d kill=%b boom=%b dead=%b hp=%h, want %b %0d %b %b %b %h",
                 cyc, bullet_hit_o, hit_idx_o, kill_pulse_o, boom_o, dead_o, health_o,
                 exp_hit, exp_idx, exp_kill, exp_boom, exp_dead, exp_health);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_priority();
    test_kill();
    test_edges();
    test_load_during_explode();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
